// File: rtl/event_timestamper.sv
// Timestamps edges of an asynchronous event against an external counter extended by a wrap counter,
// queueing {ext, q} in a FWFT FIFO. Define EVENT_TIMESTAMPER_DEGLITCH_EN to enable the input deglitcher.
module event_timestamper #(
  parameter int unsigned NBITS       = 9,
  parameter int unsigned NBITS_EXT   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEPTH_LOG2  = 3
`ifdef EVENT_TIMESTAMPER_DEGLITCH_EN
  , parameter int unsigned GLITCH_CYCLES = 3
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NBITS-1:0]           i_q,
  input  logic                       i_wrap,
  input  logic                       i_event,
  input  logic                       i_en,
  input  logic [1:0]                 i_edge_sel,
  output logic [NBITS_EXT+NBITS-1:0] o_ts,
  output logic                       o_ts_valid,
  input  logic                       i_ts_ready,
  output logic [DEPTH_LOG2:0]        o_level,
  output logic                       o_overrun,
  input  logic                       i_clr_overrun
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TSW   = NBITS_EXT + NBITS;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
`ifdef EVENT_TIMESTAMPER_DEGLITCH_EN
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1 + GLITCH_CYCLES;
  localparam int unsigned GCW        = $clog2(GLITCH_CYCLES + 1);
`else
  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int unsigned ARMW = $clog2(ARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   synced;
  logic                   level;
  logic                   prev_level;
  logic [ARMW-1:0]        arm_cnt;
  logic                   armed;
  logic                   rise;
  logic                   fall;
  logic                   edge_q;
  logic [NBITS_EXT-1:0]   ext_cnt;
  logic [NBITS_EXT-1:0]   ext_now;
  logic [TSW-1:0]         wdata;
  logic [TSW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wptr;
  logic [DEPTH_LOG2-1:0]  rptr;
  logic [DEPTH_LOG2-1:0]  rptr_nxt;
  logic [LW-1:0]          level_nxt;
  logic [TSW-1:0]         head_nxt;
  logic                   pop;
  logic                   full;
  logic                   push;
  logic                   drop;

  assign synced = sync_ff[SYNC_STAGES-1];

`ifdef EVENT_TIMESTAMPER_DEGLITCH_EN
  logic [GCW-1:0] stable_cnt;

  // Accept a new level only after GLITCH_CYCLES consecutive samples that disagree with the current one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (synced == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == GCW'(GLITCH_CYCLES - 1)) begin
      level      <= synced;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + GCW'(1);
    end
  end
`else
  assign level = synced;
`endif

  // Held off until the sync/deglitch pipeline has flushed, so a level present at reset is never an edge.
  assign armed = (arm_cnt == ARMW'(ARM_CYCLES));
  assign rise  = level & ~prev_level;
  assign fall  = ~level & prev_level;

  // Wrap pulse in the capture cycle is folded in so {ext, q} stays coherent across a counter wrap.
  assign ext_now = ext_cnt + NBITS_EXT'(i_wrap);
  assign wdata   = {ext_now, i_q};

  always_comb begin
    pop       = o_ts_valid & i_ts_ready;
    full      = (o_level == LW'(DEPTH));
    push      = edge_q & (~full | pop);
    drop      = edge_q & full & ~pop;
    level_nxt = o_level + LW'(push) - LW'(pop);
    rptr_nxt  = rptr + DEPTH_LOG2'(pop);
    head_nxt  = mem[rptr_nxt];
    // The new entry becomes the head before it lands in the array, so bypass it.
    if (push && ((o_level - LW'(pop)) == '0)) begin
      head_nxt = wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_ff    <= '0;
      prev_level <= 1'b0;
      arm_cnt    <= '0;
      edge_q     <= 1'b0;
      ext_cnt    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      o_level    <= '0;
      o_ts_valid <= 1'b0;
      o_ts       <= '0;
      o_overrun  <= 1'b0;
    end else begin
      sync_ff    <= {sync_ff[SYNC_STAGES-2:0], i_event};
      prev_level <= level;
      if (!armed) begin
        arm_cnt <= arm_cnt + ARMW'(1);
      end
      edge_q     <= armed & i_en & ((i_edge_sel[0] & rise) | (i_edge_sel[1] & fall));
      ext_cnt    <= ext_now;
      wptr       <= wptr + DEPTH_LOG2'(push);
      rptr       <= rptr_nxt;
      o_level    <= level_nxt;
      o_ts_valid <= (level_nxt != '0);
      o_ts       <= head_nxt;
      if (drop) begin
        o_overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_timestamper.sv
// Directed bench for event_timestamper: scoreboard queue of expected {ext, q} entries checked on pop.
module tb_event_timestamper;

`ifdef EVENT_TIMESTAMPER_DEGLITCH_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        i_clk;
  logic        i_rst;
  logic [8:0]  i_q;
  logic        i_wrap;
  logic        i_event;
  logic        i_en;
  logic [1:0]  i_edge_sel;
  logic [24:0] o_ts;
  logic        o_ts_valid;
  logic        i_ts_ready;
  logic [3:0]  o_level;
  logic        o_overrun;
  logic        i_clr_overrun;

  int          checks;
  int          errors;
  logic [24:0] exp_q [$];
  logic [15:0] ext_m;
  bit          ramp;
  logic [8:0]  qd;

  event_timestamper dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_q           (i_q),
    .i_wrap        (i_wrap),
    .i_event       (i_event),
    .i_en          (i_en),
    .i_edge_sel    (i_edge_sel),
    .o_ts          (o_ts),
    .o_ts_valid    (o_ts_valid),
    .i_ts_ready    (i_ts_ready),
    .o_level       (o_level),
    .o_overrun     (o_overrun),
    .i_clr_overrun (i_clr_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one cycle; when ramping, model the counter and its wrap pulse.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (ramp) begin
      i_q    = i_q + 9'd1;
      i_wrap = (i_q == 9'd0);
      if (i_wrap) ext_m = ext_m + 16'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one pulse and queue the entries it should create (FIFO assumed not being read).
  task automatic pulse(input int width, input bit rise_exp, input bit fall_exp);
    logic [8:0] qs;
    qs = i_q;
    i_event = 1'b1;
    if (rise_exp && exp_q.size() < 8) exp_q.push_back({ext_m, 9'(qs + 9'(LAT))});
    repeat (width) tick();
    qs = i_q;
    i_event = 1'b0;
    if (fall_exp && exp_q.size() < 8) exp_q.push_back({ext_m, 9'(qs + 9'(LAT))});
    repeat (LAT + 3) tick();
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    i_ts_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      chk("drain_valid", 32'(o_ts_valid), 32'd1);
      chk("drain_ts", 32'(o_ts), 32'(exp_q.pop_front()));
      tick();
    end
    i_ts_ready = 1'b0;
    chk("drain_empty", 32'(o_level), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; ext_m = 16'd0; ramp = 1'b0;
    i_rst = 1'b1; i_q = 9'd0; i_wrap = 1'b0; i_event = 1'b1; i_en = 1'b1;
    i_edge_sel = 2'b01; i_ts_ready = 1'b0; i_clr_overrun = 1'b0;

    // Reset with event held high: no capture after release
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ts", 32'(o_ts), 32'd0);
    chk("rst_valid", 32'(o_ts_valid), 32'd0);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    i_rst = 1'b0;
    repeat (20) tick();
    chk("hi_at_rst_level", 32'(o_level), 32'd0);
    chk("hi_at_rst_valid", 32'(o_ts_valid), 32'd0);

    // Capture latency on a ramping counter
    i_event = 1'b0;
    repeat (LAT + 3) tick();
    chk("fall_ignored", 32'(o_level), 32'd0);
    ramp = 1'b1; i_q = 9'h33; i_event = 1'b1;
    repeat (LAT) tick();
    chk("lat_not_yet", 32'(o_ts_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(o_ts_valid), 32'd1);
    chk("lat_ts", 32'(o_ts), 32'({16'd0, 9'(9'h33 + 9'(LAT))}));
    chk("lat_level", 32'(o_level), 32'd1);
    exp_q.push_back({16'd0, 9'(9'h33 + 9'(LAT))});
    i_event = 1'b0;
    repeat (LAT + 3) tick();
    drain();

    // Capture coincident with a wrap pulse
    ramp = 1'b0; i_q = 9'h100;
    repeat (5) begin
      i_wrap = 1'b1; ext_m = ext_m + 16'd1; tick();
      i_wrap = 1'b0; tick();
    end
    i_event = 1'b1;
    repeat (LAT) tick();
    i_q = 9'd0; i_wrap = 1'b1; ext_m = ext_m + 16'd1;
    tick();
    i_wrap = 1'b0; i_q = 9'd1;
    chk("wrap_ts", 32'(o_ts), 32'({16'd6, 9'd0}));
    exp_q.push_back({16'd6, 9'd0});
    i_event = 1'b0;
    repeat (LAT + 3) tick();
    ramp = 1'b1; i_q = 9'd20;
    pulse(4, 1'b1, 1'b0);
    chk("wrap_level", 32'(o_level), 32'd2);
    drain();

    // Edge select and enable gating
    i_q = 9'd0;
    i_edge_sel = 2'b10; pulse(4, 1'b0, 1'b1);
    chk("sel_fall", 32'(o_level), 32'd1);
    i_edge_sel = 2'b11; pulse(4, 1'b1, 1'b1);
    chk("sel_both", 32'(o_level), 32'd3);
    i_edge_sel = 2'b00; pulse(4, 1'b0, 1'b0);
    chk("sel_none", 32'(o_level), 32'd3);
    i_edge_sel = 2'b11; i_en = 1'b0; pulse(4, 1'b0, 1'b0);
    chk("en_off", 32'(o_level), 32'd3);
    i_event = 1'b1;
    repeat (LAT + 3) tick();
    i_en = 1'b1;
    repeat (LAT + 3) tick();
    chk("reenable_no_stale", 32'(o_level), 32'd3);
    i_en = 1'b0; i_event = 1'b0;
    repeat (LAT + 3) tick();
    i_en = 1'b1;
    drain();

    // Overflow, sticky overrun, set beats clear
    i_q = 9'd0; i_edge_sel = 2'b01;
    repeat (9) pulse(4, 1'b1, 1'b0);
    chk("full_level", 32'(o_level), 32'd8);
    chk("full_overrun", 32'(o_overrun), 32'd1);
    i_clr_overrun = 1'b1; tick(); i_clr_overrun = 1'b0;
    chk("overrun_clr", 32'(o_overrun), 32'd0);
    i_event = 1'b1;
    repeat (LAT) tick();
    i_clr_overrun = 1'b1; tick(); i_clr_overrun = 1'b0;
    chk("set_beats_clr", 32'(o_overrun), 32'd1);
    i_event = 1'b0;
    repeat (LAT + 3) tick();
    i_clr_overrun = 1'b1; tick(); i_clr_overrun = 1'b0;
    chk("overrun_clr2", 32'(o_overrun), 32'd0);

    // Full with simultaneous pop: push accepted, level unchanged
    qd = i_q; i_event = 1'b1;
    repeat (LAT) tick();
    chk("head_before_pop", 32'(o_ts), 32'(exp_q.pop_front()));
    exp_q.push_back({ext_m, 9'(qd + 9'(LAT))});
    i_ts_ready = 1'b1; tick(); i_ts_ready = 1'b0;
    chk("full_pop_level", 32'(o_level), 32'd8);
    chk("full_pop_overrun", 32'(o_overrun), 32'd0);
    i_event = 1'b0;
    repeat (LAT + 3) tick();
    drain();
    i_ts_ready = 1'b1;
    repeat (3) tick();
    i_ts_ready = 1'b0;
    chk("ready_empty_level", 32'(o_level), 32'd0);
    chk("ready_empty_valid", 32'(o_ts_valid), 32'd0);

`ifdef EVENT_TIMESTAMPER_DEGLITCH_EN
    // Short glitch rejected, long pulse gives both edges
    i_q = 9'd0; i_edge_sel = 2'b11;
    pulse(2, 1'b0, 1'b0);
    chk("glitch_rejected", 32'(o_level), 32'd0);
    pulse(5, 1'b1, 1'b1);
    chk("deglitch_both", 32'(o_level), 32'd2);
    drain();
    i_edge_sel = 2'b01;
`endif

    // Asynchronous reset mid-operation flushes FIFO and clears ext
    i_q = 9'd0;
    pulse(4, 1'b1, 1'b0);
    pulse(4, 1'b1, 1'b0);
    chk("pre_arst_level", 32'(o_level), 32'd2);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_level", 32'(o_level), 32'd0);
    chk("arst_valid", 32'(o_ts_valid), 32'd0);
    chk("arst_ts", 32'(o_ts), 32'd0);
    exp_q.delete();
    ext_m = 16'd0;
    i_rst = 1'b0;
    repeat (LAT + 3) tick();
    i_q = 9'd40;
    pulse(4, 1'b1, 1'b0);
    chk("post_arst_level", 32'(o_level), 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
